vga_dither_out: RTL and testbench
=================================

Name: vga_dither_out

Overview:
- Output stage between the pixel generator and the VGA pins.
- Takes 8-bit-per-channel RGB, pixel position, visible and sync signals.
- Applies 4x4 ordered (Bayer) dithering, optionally rotated per frame, and reduces each channel to the 3-bit DAC width.
- Delays syncs to stay aligned with pixel data.
- Replaces plain [7:5] truncation at the top level.

Parameters:
- DITHER_EN, 1, 1 = ordered dither; 0 = plain truncation (out = in[7:5]).
- TEMPORAL, 1, 1 = Bayer matrix offset rotates per frame; 0 = fixed matrix.
- SYNC_IDLE, 1, inactive level driven on o_vga_hsync/o_vga_vsync during reset (1 = active-low syncs).

Ports:
- i_clk  in  1  pixel clock; one clock domain.
- i_rst  in  1  synchronous reset, active-high.
- i_hsync  in  1  hsync from sync generator.
- i_vsync  in  1  vsync from sync generator.
- i_visible  in  1  active-video flag.
- i_hpos  in  10  pixel column.
- i_vpos  in  10  pixel row.
- i_r  in  8  red.
- i_g  in  8  green.
- i_b  in  8  blue.
- o_vga_hsync  out  1  hsync delayed by 2 cycles.
- o_vga_vsync  out  1  vsync delayed by 2 cycles.
- o_vga_r  out  3  dithered red.
- o_vga_g  out  3  dithered green.
- o_vga_b  out  3  dithered blue.
- o_frame  out  2  current frame phase counter.

Behaviour:
- Reset is synchronous and active-high. On a clock edge with i_rst=1:
  - both pipeline stages clear;
  - o_vga_r/g/b = 0;
  - o_vga_hsync/o_vga_vsync = SYNC_IDLE;
  - o_frame = 0.
- Reset asserted mid-frame takes effect at the next edge. After release, outputs resume 2 cycles after inputs resume, with no stale pixels.
- Pipeline is fixed at 2 cycles for every output.
  - Stage 1 registers syncs, visible and RGB, and computes threshold t.
  - Stage 2 registers the quantised RGB and syncs.
  - Input sampled at edge N appears on outputs after edge N+1.
- Frame counter: 2-bit, increments (wrapping 3->0) at the edge where i_hpos==0 and i_vpos==0. The pixel at (0,0) and all later pixels of that frame use the incremented value. o_frame shows the counter value.
- Effective frame phase f:
  - f = (i_hpos==0 && i_vpos==0) ? frame+1 : frame;
  - f = 0 when TEMPORAL=0.
- Bayer index:
  - col = (i_hpos[1:0] + 2*f[0]) mod 4;
  - row = (i_vpos[1:0] + 2*f[1]) mod 4.
- Bayer matrix B[row][col]:
  - row0 = 0 8 2 10
  - row1 = 12 4 14 6
  - row2 = 3 11 1 9
  - row3 = 15 7 13 5
- Threshold: t = B[row][col] (4 bits). The same t applies to all three channels.
- Per-channel quantisation of an 8-bit value v:
  - q = v[7:5];
  - frac = v[4:1];
  - out = q+1 if (frac > t and q < 7), else out = q.
  - Saturates at 7. 0x00 always gives 0; 0xFF always gives 7.
- DITHER_EN=0: out = v[7:5]. Frame counter still runs.
- Blanking: if i_visible=0 at sampling, the corresponding output RGB = 0 regardless of input.
- Syncs pass through unmodified (no polarity change), only delayed.
- No handshakes. The block samples every cycle, with no stall or enable.

Test Plan:
1. Reset: hold i_rst=1 for 3 cycles with i_r=0xFF, i_hsync=0 -> o_vga_r=0, hsync=vsync=1 (SYNC_IDLE=1), o_frame=0. Release -> first real pixel appears 2 cycles after the first sampled input.
2. Fixed-matrix dither, TEMPORAL=0, i_r=0x90 (q=4, frac=8), visible, scan of a 4x4 block at hpos/vpos 4..7:
   - (4,4) -> 5; (5,4) -> 4; (5,5) -> 5; (6,5) -> 4;
   - exactly 8 of 16 pixels give 5 (those with t<8).
3. Saturation and edges: i_g=0xFF -> 7 at all 16 positions; i_g=0x00 -> 0; i_g=0xE2 (q=7) -> 7; DITHER_EN=0 with i_b=0x9F -> 4 everywhere.
4. Blanking and alignment: toggle i_visible low with i_r=0xFF and pulse i_hsync for 96 cycles.
   - RGB = 0 exactly 2 cycles after visible falls.
   - hsync pulse appears 2 cycles late with width 96.
   - RGB returns exactly 2 cycles after visible rises.
5. Temporal rotation, TEMPORAL=1, i_r=0x88 (frac=4): present (0,0) four times as successive frame starts.
   - o_frame goes 1, 2, 3, 0.
   - Pixel (0,0) thresholds are 2, 3, 1, 0, giving outputs 5, 5, 5, 5.
   - At pixel (1,0) in frame 1 (t=10) the output is 4.
6. Mid-frame reset: assert i_rst for 1 cycle at hpos=300 while o_frame=2 -> o_frame=0 and RGB=0 on the next outputs. The counter increments to 1 at the next (0,0).

Source files
------------

// File: rtl/vga_dither_out.sv
// rtl/vga_dither_out.sv - VGA output stage: 4x4 ordered dither to 3-bit DAC, 2-cycle aligned syncs
module vga_dither_out #(
    parameter bit DITHER_EN = 1'b1,
    parameter bit TEMPORAL  = 1'b1,
    parameter bit SYNC_IDLE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic       i_visible,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
    output logic       o_vga_hsync,
    output logic       o_vga_vsync,
    output logic [2:0] o_vga_r,
    output logic [2:0] o_vga_g,
    output logic [2:0] o_vga_b,
    output logic [1:0] o_frame
);

    logic [1:0] frame;
    logic       frame_start;
    logic [1:0] phase;
    logic [1:0] col;
    logic [1:0] row;
    logic [3:0] thresh;

    logic       s1_hsync;
    logic       s1_vsync;
    logic       s1_visible;
    logic [6:0] s1_r;
    logic [6:0] s1_g;
    logic [6:0] s1_b;
    logic [3:0] s1_t;

    // The LSB is below the dither resolution and never affects the output.
    logic unused_lsb;
    assign unused_lsb = ^{i_r[0], i_g[0], i_b[0]};

    assign frame_start = (i_hpos == 10'd0) && (i_vpos == 10'd0);
    assign o_frame     = frame;

    // Round up when the dropped fraction beats the threshold, never past full scale.
    function automatic logic [2:0] quantise(input logic [6:0] v, input logic [3:0] t);
        logic [2:0] q;
        q = v[6:4];
        if (DITHER_EN && (v[3:0] > t) && (q != 3'd7)) begin
            quantise = q + 3'd1;
        end else begin
            quantise = q;
        end
    endfunction

    // Frame phase: the (0,0) pixel already belongs to the new frame.
    always_comb begin
        phase = 2'd0;
        if (TEMPORAL) begin
            phase = frame_start ? (frame + 2'd1) : frame;
        end
        col = i_hpos[1:0] + {phase[0], 1'b0};
        row = i_vpos[1:0] + {phase[1], 1'b0};
    end

    // 4x4 Bayer matrix lookup indexed by {row, col}.
    always_comb begin
        thresh = 4'd0;
        case ({row, col})
            4'd0:  thresh = 4'd0;
            4'd1:  thresh = 4'd8;
            4'd2:  thresh = 4'd2;
            4'd3:  thresh = 4'd10;
            4'd4:  thresh = 4'd12;
            4'd5:  thresh = 4'd4;
            4'd6:  thresh = 4'd14;
            4'd7:  thresh = 4'd6;
            4'd8:  thresh = 4'd3;
            4'd9:  thresh = 4'd11;
            4'd10: thresh = 4'd1;
            4'd11: thresh = 4'd9;
            4'd12: thresh = 4'd15;
            4'd13: thresh = 4'd7;
            4'd14: thresh = 4'd13;
            default: thresh = 4'd5;
        endcase
    end

    // Frame counter advances on the first pixel of each frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame <= 2'd0;
        end else if (frame_start) begin
            frame <= frame + 2'd1;
        end
    end

    // Stage 1: capture syncs, visibility, colour and the pixel's threshold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_hsync   <= SYNC_IDLE;
            s1_vsync   <= SYNC_IDLE;
            s1_visible <= 1'b0;
            s1_r       <= 7'd0;
            s1_g       <= 7'd0;
            s1_b       <= 7'd0;
            s1_t       <= 4'd0;
        end else begin
            s1_hsync   <= i_hsync;
            s1_vsync   <= i_vsync;
            s1_visible <= i_visible;
            s1_r       <= i_r[7:1];
            s1_g       <= i_g[7:1];
            s1_b       <= i_b[7:1];
            s1_t       <= thresh;
        end
    end

    // Stage 2: quantise to DAC width, blank outside active video, forward syncs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vga_hsync <= SYNC_IDLE;
            o_vga_vsync <= SYNC_IDLE;
            o_vga_r     <= 3'd0;
            o_vga_g     <= 3'd0;
            o_vga_b     <= 3'd0;
        end else begin
            o_vga_hsync <= s1_hsync;
            o_vga_vsync <= s1_vsync;
            o_vga_r     <= s1_visible ? quantise(s1_r, s1_t) : 3'd0;
            o_vga_g     <= s1_visible ? quantise(s1_g, s1_t) : 3'd0;
            o_vga_b     <= s1_visible ? quantise(s1_b, s1_t) : 3'd0;
        end
    end

endmodule

// File: tb/tb_vga_dither_out.sv
// tb/tb_vga_dither_out.sv - self-checking bench for vga_dither_out
module tb_vga_dither_out;

    localparam int BAYER [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    logic       clk = 1'b0;
    logic       rst;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    logic       hs_fix, vs_fix, hs_tmp, vs_tmp, hs_trn, vs_trn;
    logic [2:0] r_fix, g_fix, b_fix, r_tmp, g_tmp, b_tmp, r_trn, g_trn, b_trn;
    logic [1:0] fr_fix, fr_tmp, fr_trn;

    int errors = 0;
    int checks = 0;

    int          m_frame;
    logic [32:0] e1;
    logic [32:0] e2;
    logic [38:0] obs_all;
    logic [38:0] exp_all;

    localparam logic [32:0] IDLE = {1'b1, 1'b1, 9'd0, 1'b1, 1'b1, 9'd0, 11'd0};

    always #5 clk = ~clk;

    vga_dither_out #(.DITHER_EN(1'b1), .TEMPORAL(1'b0), .SYNC_IDLE(1'b1)) u_fix (
        .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_r(r), .i_g(g), .i_b(b),
        .o_vga_hsync(hs_fix), .o_vga_vsync(vs_fix), .o_vga_r(r_fix), .o_vga_g(g_fix),
        .o_vga_b(b_fix), .o_frame(fr_fix)
    );

    vga_dither_out #(.DITHER_EN(1'b1), .TEMPORAL(1'b1), .SYNC_IDLE(1'b1)) u_tmp (
        .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_r(r), .i_g(g), .i_b(b),
        .o_vga_hsync(hs_tmp), .o_vga_vsync(vs_tmp), .o_vga_r(r_tmp), .o_vga_g(g_tmp),
        .o_vga_b(b_tmp), .o_frame(fr_tmp)
    );

    vga_dither_out #(.DITHER_EN(1'b0), .TEMPORAL(1'b1), .SYNC_IDLE(1'b0)) u_trn (
        .i_clk(clk), .i_rst(rst), .i_hsync(hsync), .i_vsync(vsync), .i_visible(visible),
        .i_hpos(hpos), .i_vpos(vpos), .i_r(r), .i_g(g), .i_b(b),
        .o_vga_hsync(hs_trn), .o_vga_vsync(vs_trn), .o_vga_r(r_trn), .o_vga_g(g_trn),
        .o_vga_b(b_trn), .o_frame(fr_trn)
    );

    assign obs_all = {hs_fix, vs_fix, r_fix, g_fix, b_fix, fr_fix,
                      hs_tmp, vs_tmp, r_tmp, g_tmp, b_tmp, fr_tmp,
                      hs_trn, vs_trn, r_trn, g_trn, b_trn, fr_trn};
    assign exp_all = {e2[32:22], m_frame[1:0], e2[21:11], m_frame[1:0], e2[10:0], m_frame[1:0]};

    function automatic int quant(logic [7:0] v, int t, bit den, bit vis);
        int q    = int'(v) / 32;
        int frac = (int'(v) % 32) / 2;
        if (!vis) return 0;
        if (den && frac > t && q < 7) return q + 1;
        return q;
    endfunction

    function automatic logic [10:0] model_pix(bit den, bit temporal, int frame);
        int f   = temporal ? frame : 0;
        int col = (int'(hpos) % 4 + 2 * (f % 2)) % 4;
        int row = (int'(vpos) % 4 + 2 * (f / 2)) % 4;
        int t   = BAYER[row * 4 + col];
        return {hsync, vsync, 3'(quant(r, t, den, visible)), 3'(quant(g, t, den, visible)),
                3'(quant(b, t, den, visible))};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_frame = 0;
            e1 = IDLE;
            e2 = IDLE;
        end else begin
            if (hpos == 10'd0 && vpos == 10'd0) m_frame = (m_frame + 1) % 4;
            e2 = e1;
            e1 = {model_pix(1'b1, 1'b0, m_frame), model_pix(1'b1, 1'b1, m_frame),
                  model_pix(1'b0, 1'b1, m_frame)};
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; r = 8'hFF; g = 8'h00; b = 8'h00; hsync = 1'b0; vsync = 1'b0;
        visible = 1'b1; hpos = 10'd10; vpos = 10'd10;
        repeat (3) tick();
        checks++;
        if ({r_fix, hs_fix, vs_fix, fr_fix} !== {3'd0, 1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("FAIL reset_state got r=%0d hs=%b vs=%b frame=%0d exp r=0 hs=1 vs=1 frame=0",
                     r_fix, hs_fix, vs_fix, fr_fix);
        end
        checks++;
        if (obs_all !== exp_all) begin
            errors++;
            $display("FAIL reset_model got=%h exp=%h", obs_all, exp_all);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({r_fix, hs_fix} !== {3'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release_1 got r=%0d hs=%b exp r=0 hs=1", r_fix, hs_fix);
        end
        tick();
        checks++;
        if ({r_fix, hs_fix} !== {3'd7, 1'b0}) begin
            errors++;
            $display("FAIL reset_release_2 got r=%0d hs=%b exp r=7 hs=0", r_fix, hs_fix);
        end
    endtask

    task automatic test_fixed_dither();
        logic [2:0] seen [16];
        int n5 = 0;
        r = 8'h90; visible = 1'b1; hsync = 1'b1; vsync = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                hpos = 10'(4 + i % 4); vpos = 10'(4 + i / 4);
                g = 8'($urandom); b = 8'($urandom);
            end
            tick();
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL fixed_model i=%0d got=%h exp=%h", i, obs_all, exp_all);
            end
            if (i >= 1 && i <= 16) seen[i - 1] = r_fix;
        end
        for (int i = 0; i < 16; i++) if (seen[i] == 3'd5) n5++;
        checks++;
        if (seen[0] !== 3'd5) begin errors++; $display("FAIL fixed_4_4 got=%0d exp=5", seen[0]); end
        checks++;
        if (seen[1] !== 3'd4) begin errors++; $display("FAIL fixed_5_4 got=%0d exp=4", seen[1]); end
        checks++;
        if (seen[5] !== 3'd5) begin errors++; $display("FAIL fixed_5_5 got=%0d exp=5", seen[5]); end
        checks++;
        if (seen[6] !== 3'd4) begin errors++; $display("FAIL fixed_6_5 got=%0d exp=4", seen[6]); end
        checks++;
        if (n5 != 8) begin errors++; $display("FAIL fixed_count5 got=%0d exp=8", n5); end
    endtask

    task automatic test_saturation();
        logic [7:0] gv [3] = '{8'hFF, 8'h00, 8'hE2};
        logic [2:0] ge [3] = '{3'd7, 3'd0, 3'd7};
        visible = 1'b1; hsync = 1'b1; vsync = 1'b1; b = 8'h9F;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 18; i++) begin
                if (i < 16) begin
                    hpos = 10'(8 + i % 4); vpos = 10'(8 + i / 4);
                    g = gv[k]; r = 8'($urandom);
                end
                tick();
                checks++;
                if (obs_all !== exp_all) begin
                    errors++;
                    $display("FAIL sat_model k=%0d i=%0d got=%h exp=%h", k, i, obs_all, exp_all);
                end
                if (i >= 1 && i <= 16) begin
                    checks++;
                    if (g_fix !== ge[k]) begin
                        errors++;
                        $display("FAIL sat_g k=%0d i=%0d got=%0d exp=%0d", k, i, g_fix, ge[k]);
                    end
                    checks++;
                    if (b_trn !== 3'd4) begin
                        errors++;
                        $display("FAIL trunc_b i=%0d got=%0d exp=4", i, b_trn);
                    end
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [2:0] obs_r [130];
        logic       obs_hs [130];
        int lows = 0;
        r = 8'hFF; vsync = 1'b1; vpos = 10'd50;
        for (int i = 0; i < 130; i++) begin
            visible = !(i >= 10 && i < 60);
            hsync = !(i >= 20 && i < 116);
            hpos = 10'(100 + i);
            g = 8'($urandom); b = 8'($urandom);
            tick();
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL blank_model i=%0d got=%h exp=%h", i, obs_all, exp_all);
            end
            obs_r[i] = r_fix;
            obs_hs[i] = hs_fix;
            if (!hs_fix) lows++;
        end
        checks++;
        if (obs_r[10] !== 3'd7 || obs_r[11] !== 3'd0) begin
            errors++;
            $display("FAIL blank_fall got=%0d,%0d exp=7,0", obs_r[10], obs_r[11]);
        end
        checks++;
        if (obs_r[60] !== 3'd0 || obs_r[61] !== 3'd7) begin
            errors++;
            $display("FAIL blank_rise got=%0d,%0d exp=0,7", obs_r[60], obs_r[61]);
        end
        checks++;
        if (obs_hs[20] !== 1'b1 || obs_hs[21] !== 1'b0 || obs_hs[116] !== 1'b0 || obs_hs[117] !== 1'b1) begin
            errors++;
            $display("FAIL hsync_edges got=%b%b%b%b exp=1001", obs_hs[20], obs_hs[21], obs_hs[116], obs_hs[117]);
        end
        checks++;
        if (lows != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", lows); end
    endtask

    task automatic test_temporal();
        int ph [3] = '{0, 1, 2};
        int pv [3] = '{0, 0, 1};
        rst = 1'b1; tick(); rst = 1'b0;
        r = 8'h88; visible = 1'b1; hsync = 1'b1; vsync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 3; p++) begin
                hpos = 10'(ph[p]); vpos = 10'(pv[p]);
                g = 8'($urandom); b = 8'($urandom);
                tick();
                checks++;
                if (obs_all !== exp_all) begin
                    errors++;
                    $display("FAIL temporal_model k=%0d p=%0d got=%h exp=%h", k, p, obs_all, exp_all);
                end
                if (p == 0) begin
                    checks++;
                    if (fr_tmp !== 2'((k + 1) % 4)) begin
                        errors++;
                        $display("FAIL temporal_frame k=%0d got=%0d exp=%0d", k, fr_tmp, (k + 1) % 4);
                    end
                end
                if (p == 1) begin
                    checks++;
                    if (r_tmp !== 3'd5) begin
                        errors++;
                        $display("FAIL temporal_origin k=%0d got=%0d exp=5", k, r_tmp);
                    end
                end
                if (p == 2 && k == 0) begin
                    checks++;
                    if (r_tmp !== 3'd4) begin
                        errors++;
                        $display("FAIL temporal_1_0 got=%0d exp=4", r_tmp);
                    end
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        int sh [4] = '{0, 5, 0, 5};
        rst = 1'b1; tick(); rst = 1'b0;
        r = 8'hFF; visible = 1'b1; hsync = 1'b1; vsync = 1'b1;
        for (int i = 0; i < 4; i++) begin
            hpos = 10'(sh[i]); vpos = 10'(sh[i]);
            tick();
        end
        checks++;
        if (fr_fix !== 2'd2) begin errors++; $display("FAIL midreset_pre got=%0d exp=2", fr_fix); end
        for (int i = 0; i < 6; i++) begin
            hpos = 10'(298 + i); vpos = 10'd100; g = 8'($urandom); b = 8'($urandom);
            rst = (hpos == 10'd300);
            tick();
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL midreset_model i=%0d got=%h exp=%h", i, obs_all, exp_all);
            end
            if (i == 2) begin
                checks++;
                if ({fr_fix, r_fix} !== {2'd0, 3'd0}) begin
                    errors++;
                    $display("FAIL midreset_now got frame=%0d r=%0d exp frame=0 r=0", fr_fix, r_fix);
                end
            end
            if (i == 3) begin
                checks++;
                if (r_fix !== 3'd0) begin errors++; $display("FAIL midreset_next got=%0d exp=0", r_fix); end
            end
            if (i == 4) begin
                checks++;
                if (r_fix !== 3'd7) begin errors++; $display("FAIL midreset_resume got=%0d exp=7", r_fix); end
            end
        end
        rst = 1'b0; hpos = 10'd0; vpos = 10'd0;
        tick();
        checks++;
        if (fr_fix !== 2'd1) begin errors++; $display("FAIL midreset_frame got=%0d exp=1", fr_fix); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            hsync = 1'($urandom); vsync = 1'($urandom); visible = ($urandom_range(0, 3) != 0);
            hpos = 10'($urandom_range(0, 7)); vpos = 10'($urandom_range(0, 3));
            r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
            tick();
            checks++;
            if (obs_all !== exp_all) begin
                errors++;
                $display("FAIL random_model i=%0d got=%h exp=%h", i, obs_all, exp_all);
            end
        end
    endtask

    initial begin
        m_frame = 0; e1 = IDLE; e2 = IDLE;
        rst = 1'b1; hsync = 1'b1; vsync = 1'b1; visible = 1'b0;
        hpos = 10'd10; vpos = 10'd10; r = 8'h00; g = 8'h00; b = 8'h00;
        test_reset();
        test_fixed_dither();
        test_saturation();
        test_blanking();
        test_temporal();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
